mod_updown_counter: RTL
=======================

# mod_updown_counter

Parametrised modulo up/down counter: the next generation of the team's fixed-N mod counter. It adds:
- a run-time programmable modulus,
- a programmable step size,
- synchronous load and count enable,
- wrap or saturate mode at the boundaries,
- a registered terminal-count strobe and a wrap-event counter.

It serves as the general timebase/sequence counter for downstream blocks that need a cascadable modulo count.

## Interface
- `W`, 8, count/modulus/load width
- `N`, 10, reset modulus; must satisfy 2 ≤ N ≤ 2^W
- `SW`, 4, step width
- `CW`, 8, wrap-event counter width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `en`  in  1  count enable
- `up_down`  in  1  1 = count up, 0 = count down
- `step`  in  SW  increment per enabled cycle; 0 = hold
- `sat_mode`  in  1  0 = wrap at boundaries, 1 = saturate
- `load`  in  1  synchronous load of `load_val`
- `load_val`  in  W  load value
- `mod_we`  in  1  write new modulus
- `mod_val`  in  W+1  new modulus value
- `count`  out  W  current count, always in [0, mod-1]
- `mod`  out  W+1  active modulus
- `tc`  out  1  one-cycle terminal-count strobe
- `mod_err`  out  1  one-cycle strobe: rejected `mod_we`
- `wraps`  out  CW  number of wrap/saturate events since reset, rolls over

## Operation
- Reset values: `count` = 0, `mod` = N, `tc` = 0, `mod_err` = 0, `wraps` = 0.
- Per-edge priority: `mod_we` > `load` > `en` count step > hold.
- **Modulus write:**
  - `mod_val` < 2 or > 2^W: rejected; `mod` unchanged, `mod_err` = 1 for one cycle, and the cycle then proceeds as if `mod_we` were 0.
  - Accepted: `mod` updates. If current `count` ≥ new `mod`, `count` becomes 0; otherwise `count` holds. No step is taken that cycle.
- **Load:** `count` ← `load_val` if `load_val` < `mod`, else `mod`-1. `tc` is not asserted.
- **Step:** effective step s = min(`step`, `mod`-1).
  - s = 0 or `en` = 0: hold.
  - Up, `count` + s < `mod`: `count` ← `count` + s.
  - Up, `count` + s ≥ `mod`:
    - wrap mode: `count` ← `count` + s − `mod`
    - saturate mode: `count` ← `mod`-1
  - Down, s ≤ `count`: `count` ← `count` − s.
  - Down, s > `count`:
    - wrap mode: `count` ← `count` + `mod` − s
    - saturate mode: `count` ← 0
  - All arithmetic is done at W+1 bits, so there is no intermediate overflow.
- **Boundary event:** a step that takes the up/down boundary branch (`count` + s ≥ `mod`, or s > `count`), including in saturate mode, sets `tc` = 1 for one cycle and increments `wraps` (modulo 2^CW).
  - In saturate mode, when already at the limit, every enabled nonzero step in the limit direction is still an event, so `tc` repeats each cycle.
- `up_down`, `sat_mode` and `step` are sampled every edge and may change any cycle.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Latency is 1 cycle: effects of inputs sampled at edge k are visible after edge k.
- `tc` is coincident with the post-wrap `count` value and is low in every other cycle.
- Reset asserted mid-count: outputs go to reset values immediately (asynchronously). Counting resumes on the first edge after deassertion with `mod` = N.

## Structure
- A shared package `counter_pkg` holds:
  - the direction constants `DIR_UP` = 1 and `DIR_DOWN` = 0
  - the mode constants `MODE_WRAP` = 0 and `MODE_SAT` = 1
  - a modulus-legality function
- Sub-module `mod_step_calc` is combinational. It takes `count`, `mod`, s, direction and mode, and returns the next count and a boundary flag. The top level holds all registers and the priority logic.

## Test plan
- Reset, then `en`=1, up, `step`=1, `mod`=10, wrap, for 12 cycles -> count 1..9, 0, 1, 2; `tc` high only with count 0; `wraps`=1.
- Down, `step`=3, `count`=1, `mod`=10, wrap -> count 8, `tc`=1; next cycle count 5, `tc`=0.
- Saturate, up, `step`=4, `count`=7, `mod`=10 -> count 9 with `tc`=1; the next enabled cycle holds 9 and `tc`=1 again.
- `count`=8, `mod_we` with `mod_val`=6 -> `mod`=6, count 0. `mod_we` with `mod_val`=1 -> `mod_err` pulse, `mod` stays 6.
- `load`=1, `load_val`=15 with `mod`=10 -> count 9. Same cycle with `en`=1: the load wins and no step is applied.
- Assert `reset` asynchronously mid-count at count 5 -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // A modulus is usable when it is in [2, 2^w].
  function automatic logic mod_legal(input logic [31:0] mod_v, input int unsigned w);
    return (mod_v >= 32'd2) && (mod_v <= (32'd1 << w));
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle between a counter client and mod_updown_counter.
interface mod_updown_counter_if #(
  parameter int W  = 8,
  parameter int SW = 4,
  parameter int CW = 8
);
  logic          en;
  logic          up_down;
  logic [SW-1:0] step;
  logic          sat_mode;
  logic          load;
  logic [W-1:0]  load_val;
  logic          mod_we;
  logic [W:0]    mod_val;
  logic [W-1:0]  count;
  logic [W:0]    mod;
  logic          tc;
  logic          mod_err;
  logic [CW-1:0] wraps;

  modport master (
    output en, up_down, step, sat_mode, load, load_val, mod_we, mod_val,
    input  count, mod, tc, mod_err, wraps
  );

  modport slave (
    input  en, up_down, step, sat_mode, load, load_val, mod_we, mod_val,
    output count, mod, tc, mod_err, wraps
  );
endinterface

// File: rtl/mod_step_calc.sv
// Combinational next-count for one step of size s inside modulus mod.
module mod_step_calc
  import counter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_count,
  input  logic [W:0]   i_mod,
  input  logic [W:0]   i_step,
  input  logic         i_dir,
  input  logic         i_mode,
  output logic [W-1:0] o_next,
  output logic         o_boundary
);

  logic [W:0] w_cnt_ext;
  logic [W:0] w_res;

  // W+1-bit arithmetic: count + s and count + mod cannot overflow.
  always_comb begin
    w_cnt_ext  = {1'b0, i_count};
    w_res      = w_cnt_ext;
    o_boundary = 1'b0;
    if (i_step == '0) begin
      w_res = w_cnt_ext;
    end else if (i_dir == DIR_UP) begin
      w_res = w_cnt_ext + i_step;
      if (w_res >= i_mod) begin
        o_boundary = 1'b1;
        if (i_mode == MODE_SAT) begin
          w_res = i_mod - (W+1)'(1);
        end else begin
          w_res = w_res - i_mod;
        end
      end else begin
        o_boundary = 1'b0;
      end
    end else begin
      if (i_step <= w_cnt_ext) begin
        w_res = w_cnt_ext - i_step;
      end else begin
        o_boundary = 1'b1;
        if (i_mode == MODE_SAT) begin
          w_res = '0;
        end else begin
          w_res = w_cnt_ext + i_mod - i_step;
        end
      end
    end
    o_next = w_res[W-1:0];
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Programmable-modulus up/down counter with load, wrap/saturate and event counting.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 10,
  parameter int SW = 4,
  parameter int CW = 8
) (
  input  logic clk,
  input  logic reset,
  mod_updown_counter_if.slave bus
);

  localparam int XW = (SW > W + 1) ? SW : W + 1;

  logic [W-1:0]  r_count;
  logic [W:0]    r_mod;
  logic          r_tc;
  logic          r_mod_err;
  logic [CW-1:0] r_wraps;

  logic [W-1:0]  w_count_nxt;
  logic [W:0]    w_mod_nxt;
  logic          w_tc_nxt;
  logic          w_err_nxt;
  logic [CW-1:0] w_wraps_nxt;
  logic          w_mod_ok;
  logic [W:0]    w_mod_m1;
  logic [XW-1:0] w_step_x;
  logic [XW-1:0] w_mm1_x;
  logic [XW-1:0] w_s_x;
  logic [W:0]    w_s;
  logic [W-1:0]  w_step_next;
  logic          w_step_bnd;

  // Effective step is clamped to mod-1 so a single step never crosses twice.
  always_comb begin
    w_mod_m1 = r_mod - (W+1)'(1);
    w_step_x = XW'(bus.step);
    w_mm1_x  = XW'(w_mod_m1);
    if (w_step_x < w_mm1_x) begin
      w_s_x = w_step_x;
    end else begin
      w_s_x = w_mm1_x;
    end
    w_s = w_s_x[W:0];
  end

  mod_step_calc #(.W(W)) u_step (
    .i_count    (r_count),
    .i_mod      (r_mod),
    .i_step     (w_s),
    .i_dir      (bus.up_down),
    .i_mode     (bus.sat_mode),
    .o_next     (w_step_next),
    .o_boundary (w_step_bnd)
  );

  // Priority: accepted modulus write, then load, then enabled step.
  always_comb begin
    w_mod_ok    = mod_legal(32'(bus.mod_val), W);
    w_count_nxt = r_count;
    w_mod_nxt   = r_mod;
    w_tc_nxt    = 1'b0;
    w_err_nxt   = bus.mod_we & ~w_mod_ok;
    w_wraps_nxt = r_wraps;
    if (bus.mod_we && w_mod_ok) begin
      w_mod_nxt = bus.mod_val;
      if ({1'b0, r_count} >= bus.mod_val) begin
        w_count_nxt = '0;
      end else begin
        w_count_nxt = r_count;
      end
    end else if (bus.load) begin
      if ({1'b0, bus.load_val} < r_mod) begin
        w_count_nxt = bus.load_val;
      end else begin
        w_count_nxt = w_mod_m1[W-1:0];
      end
    end else if (bus.en) begin
      w_count_nxt = w_step_next;
      if (w_step_bnd) begin
        w_tc_nxt    = 1'b1;
        w_wraps_nxt = r_wraps + CW'(1);
      end else begin
        w_tc_nxt    = 1'b0;
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // State registers; reset restores the power-on modulus N.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_mod     <= (W+1)'(N);
      r_tc      <= 1'b0;
      r_mod_err <= 1'b0;
      r_wraps   <= '0;
    end else begin
      r_count   <= w_count_nxt;
      r_mod     <= w_mod_nxt;
      r_tc      <= w_tc_nxt;
      r_mod_err <= w_err_nxt;
      r_wraps   <= w_wraps_nxt;
    end
  end

  assign bus.count   = r_count;
  assign bus.mod     = r_mod;
  assign bus.tc      = r_tc;
  assign bus.mod_err = r_mod_err;
  assign bus.wraps   = r_wraps;

endmodule
